// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage data-memory access controller.
// Turns the EX/MEM MemRead/MemWrite request into one single-word req/ack
// transaction and freezes the pipeline via stall_o until it completes.
// Optional build macro: MEM_TIMEOUT_EN. When defined, an ACCESS that waits
// TIMEOUT_CYCLES without ack is aborted, the load returns 32'hDEADBEEF and a
// sticky err_o is raised. When undefined, ACCESS waits indefinitely and
// err_o is tied low.

module mem_access_ctrl #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              err_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } state_t;

  state_t              state_r;
  logic                mem_req_r;
  logic                mem_we_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [DATA_W-1:0]   mem_wdata_r;
  logic [DATA_W-1:0]   rdata_r;
  logic                req_s;
  logic                stall_s;
  logic                timeout_s;
  logic                unused_s;

  // The two byte-offset bits never reach the word-addressed memory.
  assign unused_s = ^{addr_i[1:0], (TIMEOUT_CYCLES > 0)};

  assign req_s = MemRead_i | MemWrite_i;

`ifdef MEM_TIMEOUT_EN
  localparam int                CNT_W     = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [DATA_W-1:0] TMO_RDATA = DATA_W'(32'hDEADBEEF);

  logic [CNT_W-1:0] tmo_cnt_r;
  logic             err_r;

  // The last allowed ACCESS cycle without ack aborts the transaction; an ack
  // in that same cycle still completes normally.
  assign timeout_s = (state_r == ST_ACCESS) && !mem_ack_i && (tmo_cnt_r == TMO_LAST);

  // Wait counter: cleared when an access is launched, counts ACCESS cycles without ack.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == ST_IDLE) && req_s) begin
      tmo_cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == ST_ACCESS) && !mem_ack_i && !timeout_s) begin
      tmo_cnt_r <= tmo_cnt_r + CNT_ONE;
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end

  assign err_o = err_r;
`else
  assign timeout_s = 1'b0;
  assign err_o     = 1'b0;
`endif

  // Stall is combinational in IDLE so EX/MEM holds in the very cycle the
  // request first appears; DONE releases the pipeline for one edge.
  always_comb begin
    stall_s = 1'b0;
    case (state_r)
      ST_IDLE:   stall_s = req_s;
      ST_ACCESS: stall_s = 1'b1;
      ST_DONE:   stall_s = 1'b0;
      default:   stall_s = 1'b0;
    endcase
  end

  // Access FSM with registered memory-side outputs and load-data register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= ST_IDLE;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
      rdata_r     <= {DATA_W{1'b0}};
`ifdef MEM_TIMEOUT_EN
      err_r       <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_s) begin
            // Read and write together is illegal; the write wins.
            mem_we_r    <= MemWrite_i;
            mem_addr_r  <= {addr_i[ADDR_W-1:2], 2'b00};
            mem_wdata_r <= wdata_i;
            mem_req_r   <= 1'b1;
            state_r     <= ST_ACCESS;
          end else begin
            mem_req_r   <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          if (mem_ack_i) begin
            if (!mem_we_r) begin
              rdata_r <= mem_rdata_i;
            end else begin
              rdata_r <= rdata_r;
            end
            mem_req_r <= 1'b0;
            state_r   <= ST_DONE;
          end else if (timeout_s) begin
`ifdef MEM_TIMEOUT_EN
            if (!mem_we_r) begin
              rdata_r <= TMO_RDATA;
            end else begin
              rdata_r <= rdata_r;
            end
            err_r     <= 1'b1;
`endif
            mem_req_r <= 1'b0;
            state_r   <= ST_DONE;
          end else begin
            mem_req_r <= 1'b1;
            state_r   <= ST_ACCESS;
          end
        end
        ST_DONE: begin
          // EX/MEM still shows the finished instruction here; ignore it.
          mem_req_r <= 1'b0;
          state_r   <= ST_IDLE;
        end
        default: begin
          mem_req_r <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  assign stall_o     = stall_s;
  assign mem_req_o   = mem_req_r;
  assign mem_we_o    = mem_we_r;
  assign mem_addr_o  = mem_addr_r;
  assign mem_wdata_o = mem_wdata_r;
  assign rdata_o     = rdata_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: transaction-level model (request cycle T, end
// cycle E) checked every cycle, plus hand-computed literal expectations.
// Build with MEM_TIMEOUT_EN defined to also cover the timeout feature.

module tb_mem_access_ctrl;

`ifdef MEM_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 256;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        MemRead_i, MemWrite_i;
  logic [31:0] addr_i, wdata_i;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        err_o;

  mem_access_ctrl #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .MemRead_i(MemRead_i),
    .MemWrite_i(MemWrite_i),
    .addr_i(addr_i),
    .wdata_i(wdata_i),
    .stall_o(stall_o),
    .rdata_o(rdata_o),
    .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i),
    .mem_rdata_i(mem_rdata_i),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Transaction model: the current access was presented in cycle m_T and
  // finishes (ack or timeout) in cycle m_E; DONE is m_E+1.
  bit          model_en = 1'b0;
  bit          m_act = 1'b0;
  int          m_T = 0, m_E = 0;
  bit          m_wr = 1'b0, m_to = 1'b0;
  logic [31:0] m_addr = 32'h0, m_wdata = 32'h0, m_rd_new = 32'h0;
  logic [31:0] m_rdata = 32'h0;
  bit          m_err = 1'b0;

  function automatic logic [31:0] exp_rdata();
    return (m_act && !m_wr && cyc > m_E) ? m_rd_new : m_rdata;
  endfunction

  function automatic bit exp_err();
    return m_err | (m_act && m_to && cyc > m_E);
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk_i) begin : compare_blk
    bit in_win, in_req;
    if (model_en) begin
      in_win = m_act && (cyc >= m_T) && (cyc <= m_E);
      in_req = m_act && (cyc >  m_T) && (cyc <= m_E);
      chk("stall", 32'(stall_o), 32'(in_win));
      chk("req", 32'(mem_req_o), 32'(in_req));
      chk("rdata", rdata_o, exp_rdata());
      chk("err", 32'(err_o), 32'(exp_err()));
      if (in_req) begin
        chk("addr", mem_addr_o, m_addr);
        chk("we", 32'(mem_we_o), 32'(m_wr));
        if (m_wr) chk("wdata", mem_wdata_o, m_wdata);
      end
    end
  end

  task automatic do_access(input bit rd, input bit wr, input logic [31:0] a,
                           input logic [31:0] wd, input int k, input logic [31:0] rv,
                           input bit to, output int n_stall, output int n_req,
                           output int t0);
    @(posedge clk_i); #1;
    m_rdata  = exp_rdata();
    m_err    = exp_err();
    t0       = cyc;
    m_T      = cyc;
    m_E      = to ? cyc + TO : cyc + 1 + k;
    m_wr     = wr;
    m_to     = to;
    m_addr   = a & 32'hFFFF_FFFC;
    m_wdata  = wd;
    m_rd_new = to ? 32'hDEAD_BEEF : rv;
    m_act    = 1'b1;
    MemRead_i  = rd;
    MemWrite_i = wr;
    addr_i     = a;
    wdata_i    = wd;
    n_stall = 0;
    n_req   = 0;
    for (int c = m_T; c <= m_E + 1; c++) begin
      if (c != m_T) begin
        @(posedge clk_i); #1;
      end
      if (!to && c == m_T + 1 + k) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = rv;
      end else begin
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'hBAD0_0000 ^ 32'(c);
      end
      @(negedge clk_i);
      if (stall_o) n_stall++;
      if (mem_req_o) n_req++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i); #1;
      MemRead_i  = 1'b0;
      MemWrite_i = 1'b0;
      mem_ack_i  = 1'b0;
    end
  endtask

  int ns, nr, t1, t2;

  initial begin
    rst_i = 1'b1;
    MemRead_i = 1'b0;
    MemWrite_i = 1'b0;
    addr_i = 32'h0;
    wdata_i = 32'h0;
    mem_ack_i = 1'b0;
    mem_rdata_i = 32'h0;
    #12;
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_req", 32'(mem_req_o), 32'd0);
    chk("rst_we", 32'(mem_we_o), 32'd0);
    chk("rst_addr", mem_addr_o, 32'h0);
    chk("rst_wdata", mem_wdata_o, 32'h0);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_err", 32'(err_o), 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    model_en = 1'b1;
    idle(2);

    // Single load, ack 3 cycles after req.
    do_access(1'b1, 1'b0, 32'h0000_0107, 32'h0, 3, 32'h1234_5678, 1'b0, ns, nr, t1);
    chk("ld_stall_cycles", 32'(ns), 32'd5);
    chk("ld_req_cycles", 32'(nr), 32'd4);
    chk("ld_rdata_done", rdata_o, 32'h1234_5678);
    chk("ld_addr", mem_addr_o, 32'h0000_0104);
    chk("ld_we", 32'(mem_we_o), 32'd0);
    idle(2);

    // Store, zero-wait.
    do_access(1'b0, 1'b1, 32'h0000_0040, 32'hCAFE_F00D, 0, 32'h0, 1'b0, ns, nr, t1);
    chk("st_stall_cycles", 32'(ns), 32'd2);
    chk("st_req_cycles", 32'(nr), 32'd1);
    chk("st_we", 32'(mem_we_o), 32'd1);
    chk("st_wdata", mem_wdata_o, 32'hCAFE_F00D);
    chk("st_rdata_kept", rdata_o, 32'h1234_5678);
    idle(1);

    // Back-to-back load then store with the pipeline advancing.
    do_access(1'b1, 1'b0, 32'h0000_0200, 32'h0, 0, 32'hA5A5_0001, 1'b0, ns, nr, t1);
    chk("b2b_ld_stall", 32'(ns), 32'd2);
    do_access(1'b0, 1'b1, 32'h0000_0204, 32'h0F0F_0F0F, 0, 32'h0, 1'b0, ns, nr, t2);
    chk("b2b_st_stall", 32'(ns), 32'd2);
    chk("b2b_st_req", 32'(nr), 32'd1);
    chk("b2b_spacing", 32'(t2 - t1), 32'd3);
    chk("b2b_rdata", rdata_o, 32'hA5A5_0001);
    idle(1);

    // Read and write both high: treated as a write.
    do_access(1'b1, 1'b1, 32'h0000_0083, 32'h1111_2222, 1, 32'h9999_9999, 1'b0, ns, nr, t1);
    chk("both_stall", 32'(ns), 32'd3);
    chk("both_we", 32'(mem_we_o), 32'd1);
    chk("both_addr", mem_addr_o, 32'h0000_0080);
    chk("both_rdata_kept", rdata_o, 32'hA5A5_0001);
    idle(1);

    // Stray ack while idle is ignored.
    @(posedge clk_i); #1;
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'hFFFF_0000;
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;
    @(negedge clk_i);
    chk("stray_ack_rdata", rdata_o, 32'hA5A5_0001);
    idle(1);

`ifdef MEM_TIMEOUT_EN
    // Ack in the last allowed cycle wins over the timeout.
    do_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, TO - 1, 32'h7777_8888, 1'b0, ns, nr, t1);
    chk("edge_ack_rdata", rdata_o, 32'h7777_8888);
    chk("edge_ack_err", 32'(err_o), 32'd0);
    chk("edge_ack_stall", 32'(ns), 32'd5);
    idle(1);
    // Load with no ack times out.
    do_access(1'b1, 1'b0, 32'h0000_0014, 32'h0, 0, 32'h0, 1'b1, ns, nr, t1);
    chk("tmo_req_cycles", 32'(nr), 32'd4);
    chk("tmo_rdata", rdata_o, 32'hDEAD_BEEF);
    chk("tmo_err", 32'(err_o), 32'd1);
    idle(1);
    do_access(1'b1, 1'b0, 32'h0000_0018, 32'h0, 0, 32'h0A0B_0C0D, 1'b0, ns, nr, t1);
    chk("tmo_err_sticky", 32'(err_o), 32'd1);
    chk("tmo_after_rdata", rdata_o, 32'h0A0B_0C0D);
    idle(1);
`endif

    // Reset in the middle of an access.
    @(posedge clk_i); #1;
    m_rdata = exp_rdata();
    m_err   = exp_err();
    m_act = 1'b1; m_T = cyc; m_E = cyc + 1000; m_wr = 1'b0; m_to = 1'b0;
    m_addr = 32'h0000_0300; m_wdata = 32'h0;
    MemRead_i = 1'b1;
    addr_i = 32'h0000_0300;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("pre_rst_req", 32'(mem_req_o), 32'd1);
    model_en = 1'b0;
    #2;
    rst_i = 1'b1;
    MemRead_i = 1'b0;
    #1;
    chk("rst_mid_req", 32'(mem_req_o), 32'd0);
    chk("rst_mid_stall", 32'(stall_o), 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'h5555_AAAA;
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;
    m_act = 1'b0; m_rdata = 32'h0; m_err = 1'b0;
    model_en = 1'b1;
    @(negedge clk_i);
    chk("late_ack_rdata", rdata_o, 32'h0);
    chk("late_ack_req", 32'(mem_req_o), 32'd0);
    chk("late_ack_err", 32'(err_o), 32'd0);

    // Recovery after reset.
    do_access(1'b1, 1'b0, 32'h0000_0008, 32'h0, 0, 32'h1357_2468, 1'b0, ns, nr, t1);
    chk("post_rst_rdata", rdata_o, 32'h1357_2468);
    chk("post_rst_stall", 32'(ns), 32'd2);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
